// File: rtl/sys_pll_ctrl.sv
// PLL controller: divider handshake, PLL reset sequencing and lock qualification.
// Optional macro SYS_PLL_RELOCK_EN: lock loss in RUN re-runs the reset sequence (max 3 tries).
module sys_pll_ctrl #(
  parameter int NUM_OUT      = 1,
  parameter int DEF_IDIV     = 1,
  parameter int DEF_FBDIV    = 1,
  parameter int DEF_MDIV     = 8,
  parameter int DEF_ODIV     = 16,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [6:0]             cfg_idiv,
  input  logic [6:0]             cfg_fbdiv,
  input  logic [7:0]             cfg_mdiv,
  input  logic [8*NUM_OUT-1:0]   cfg_odiv,
  input  logic [NUM_OUT-1:0]     cfg_en,
  input  logic                   pll_lock,
  output logic                   pll_reset,
  output logic [5:0]             pll_idsel,
  output logic [5:0]             pll_fbdsel,
  output logic [6:0]             pll_mdsel,
  output logic [7*NUM_OUT-1:0]   pll_odsel,
  output logic [NUM_OUT-1:0]     pll_enclk,
  output logic                   locked,
  output logic                   busy,
  output logic                   err_range,
  output logic                   err_timeout,
  output logic                   lock_lost
);

  localparam int CNT_MAX0 = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > LOCK_STABLE) ? CNT_MAX0 : LOCK_STABLE;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_APPLY, ST_RST, ST_WAIT_LOCK, ST_RUN, ST_FAULT
  } state_e;

  function automatic logic [5:0] enc6(input logic [6:0] n);
    logic [6:0] t;
    t = 7'd64 - n;
    return t[5:0];
  endfunction

  function automatic logic [6:0] enc7(input logic [7:0] n);
    logic [7:0] t;
    t = 8'd128 - n;
    return t[6:0];
  endfunction

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]       stab_q, stab_d, stab_inc;
  logic                   lock_ok_q, lock_ok_d;
  logic [5:0]             idsel_q, idsel_d, fbdsel_q, fbdsel_d;
  logic [6:0]             mdsel_q, mdsel_d;
  logic [7*NUM_OUT-1:0]   odsel_q, odsel_d, odsel_new;
  logic [NUM_OUT-1:0]     en_q, en_d;
  logic                   err_range_q, err_range_d;
  logic                   err_timeout_q, err_timeout_d;
  logic                   lock_lost_q, lock_lost_d;
  logic [1:0]             sync_q;
  logic                   lock_s, accept, cfg_legal;
`ifdef SYS_PLL_RELOCK_EN
  logic [1:0]             attempt_q, attempt_d;
`endif

  assign lock_s   = sync_q[1];
  assign cnt_inc  = cnt_q + 1'b1;
  assign stab_inc = stab_q + 1'b1;
  assign accept   = cfg_valid && cfg_ready;

  always_comb begin
    cfg_legal = (cfg_idiv  >= 7'd1) && (cfg_idiv  <= 7'd64) &&
                (cfg_fbdiv >= 7'd1) && (cfg_fbdiv <= 7'd64) &&
                (cfg_mdiv  >= 8'd2) && (cfg_mdiv  <= 8'd128);
    odsel_new = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (cfg_odiv[8*i +: 8] == 8'd0 || cfg_odiv[8*i +: 8] > 8'd128) cfg_legal = 1'b0;
      odsel_new[7*i +: 7] = enc7(cfg_odiv[8*i +: 8]);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    stab_d        = stab_q;
    lock_ok_d     = lock_ok_q;
    idsel_d       = idsel_q;
    fbdsel_d      = fbdsel_q;
    mdsel_d       = mdsel_q;
    odsel_d       = odsel_q;
    en_d          = en_q;
    err_range_d   = err_range_q;
    err_timeout_d = err_timeout_q;
    lock_lost_d   = lock_lost_q;
`ifdef SYS_PLL_RELOCK_EN
    attempt_d     = attempt_q;
`endif
    case (state_q)
      ST_APPLY: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
      ST_RST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          stab_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_LOCK: begin
        cnt_d  = cnt_inc;
        stab_d = lock_s ? stab_inc : '0;
        if (lock_s && stab_inc == CNT_W'(LOCK_STABLE)) begin
          state_d   = ST_RUN;
          lock_ok_d = 1'b1;
`ifdef SYS_PLL_RELOCK_EN
          attempt_d = 2'd0;
`endif
        end else if (cnt_inc == CNT_W'(LOCK_TIMEOUT)) begin
`ifdef SYS_PLL_RELOCK_EN
          // A failed relock retries until three attempts have been spent.
          if (attempt_q != 2'd0 && attempt_q != 2'd3) begin
            state_d   = ST_RST;
            cnt_d     = '0;
            attempt_d = attempt_q + 2'd1;
          end else begin
            state_d       = ST_FAULT;
            err_timeout_d = 1'b1;
          end
`else
          state_d       = ST_FAULT;
          err_timeout_d = 1'b1;
`endif
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          lock_lost_d = 1'b1;
`ifdef SYS_PLL_RELOCK_EN
          state_d   = ST_RST;
          cnt_d     = '0;
          attempt_d = 2'd1;
`else
          lock_ok_d = 1'b0;
          stab_d    = '0;
`endif
        end else if (!lock_ok_q) begin
          stab_d = stab_inc;
          if (stab_inc == CNT_W'(LOCK_STABLE)) lock_ok_d = 1'b1;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_APPLY;
    endcase

    if (accept) begin
      if (cfg_legal) begin
        state_d       = ST_APPLY;
        cnt_d         = '0;
        stab_d        = '0;
        lock_ok_d     = 1'b0;
        idsel_d       = enc6(cfg_idiv);
        fbdsel_d      = enc6(cfg_fbdiv);
        mdsel_d       = enc7(cfg_mdiv);
        odsel_d       = odsel_new;
        en_d          = cfg_en;
        err_range_d   = 1'b0;
        err_timeout_d = 1'b0;
        lock_lost_d   = 1'b0;
`ifdef SYS_PLL_RELOCK_EN
        attempt_d     = 2'd0;
`endif
      end else begin
        err_range_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_APPLY;
      cnt_q         <= '0;
      stab_q        <= '0;
      lock_ok_q     <= 1'b0;
      idsel_q       <= enc6(7'(DEF_IDIV));
      fbdsel_q      <= enc6(7'(DEF_FBDIV));
      mdsel_q       <= enc7(8'(DEF_MDIV));
      odsel_q       <= {NUM_OUT{enc7(8'(DEF_ODIV))}};
      en_q          <= '1;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      lock_lost_q   <= 1'b0;
      sync_q        <= 2'b00;
`ifdef SYS_PLL_RELOCK_EN
      attempt_q     <= 2'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stab_q        <= stab_d;
      lock_ok_q     <= lock_ok_d;
      idsel_q       <= idsel_d;
      fbdsel_q      <= fbdsel_d;
      mdsel_q       <= mdsel_d;
      odsel_q       <= odsel_d;
      en_q          <= en_d;
      err_range_q   <= err_range_d;
      err_timeout_q <= err_timeout_d;
      lock_lost_q   <= lock_lost_d;
      sync_q        <= {sync_q[0], pll_lock};
`ifdef SYS_PLL_RELOCK_EN
      attempt_q     <= attempt_d;
`endif
    end
  end

  assign cfg_ready   = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_FAULT);
  assign busy        = (state_q == ST_APPLY) || (state_q == ST_RST) || (state_q == ST_WAIT_LOCK);
  assign pll_reset   = (state_q == ST_RST);
  assign locked      = (state_q == ST_RUN) && lock_ok_q && lock_s;
  assign pll_enclk   = locked ? en_q : '0;
  assign pll_idsel   = idsel_q;
  assign pll_fbdsel  = fbdsel_q;
  assign pll_mdsel   = mdsel_q;
  assign pll_odsel   = odsel_q;
  assign err_range   = err_range_q;
  assign err_timeout = err_timeout_q;
  assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_sys_pll_ctrl.sv
// Self-checking bench for sys_pll_ctrl: vector table of divider offers plus
// hand-written reset, timeout, lock-drop and mid-sequence-reset sequences.
module tb_sys_pll_ctrl;
  localparam int N  = 2;
  localparam int LS = 8;
  localparam int LT = 100;
  localparam int RC = 16;

  logic            clk = 1'b0;
  logic            rst, cfg_valid, cfg_ready, pll_lock, pll_reset;
  logic [6:0]      cfg_idiv, cfg_fbdiv;
  logic [7:0]      cfg_mdiv;
  logic [8*N-1:0]  cfg_odiv;
  logic [N-1:0]    cfg_en, pll_enclk;
  logic [5:0]      pll_idsel, pll_fbdsel;
  logic [6:0]      pll_mdsel;
  logic [7*N-1:0]  pll_odsel;
  logic            locked, busy, err_range, err_timeout, lock_lost;

  sys_pll_ctrl #(
    .NUM_OUT(N), .RST_CYCLES(RC), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idiv(cfg_idiv), .cfg_fbdiv(cfg_fbdiv), .cfg_mdiv(cfg_mdiv),
    .cfg_odiv(cfg_odiv), .cfg_en(cfg_en), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel),
    .pll_mdsel(pll_mdsel), .pll_odsel(pll_odsel), .pll_enclk(pll_enclk),
    .locked(locked), .busy(busy), .err_range(err_range),
    .err_timeout(err_timeout), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  idiv;
    logic [6:0]  fbdiv;
    logic [7:0]  mdiv;
    logic [15:0] odiv;
    logic [1:0]  en;
    bit          legal;
    logic [5:0]  e_id;
    logic [5:0]  e_fb;
    logic [6:0]  e_md;
    logic [13:0] e_od;
  } vec_t;

  vec_t tbl[8];
  vec_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Expected divider selects currently applied in the DUT.
  logic [5:0]  m_id, m_fb;
  logic [6:0]  m_md;
  logic [13:0] m_od;
  logic [1:0]  m_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    m_id = 6'd63; m_fb = 6'd63; m_md = 7'd120; m_od = {7'd112, 7'd112}; m_en = 2'b11;
  endtask

  task automatic check_sels(input string tag);
    check({tag, "_idsel"},  pll_idsel,  m_id);
    check({tag, "_fbdsel"}, pll_fbdsel, m_fb);
    check({tag, "_mdsel"},  pll_mdsel,  m_md);
    check({tag, "_odsel"},  pll_odsel,  m_od);
  endtask

  task automatic offer(input vec_t v);
    vec_t r;
    int n = 0;
    while (!cfg_ready && n < 500) begin step(); n++; end
    check("ready_wait", cfg_ready, 1);
    cfg_idiv = v.idiv; cfg_fbdiv = v.fbdiv; cfg_mdiv = v.mdiv;
    cfg_odiv = v.odiv; cfg_en = v.en; cfg_valid = 1'b1;
    if (v.legal) pll_lock = 1'b0;
    sb_q.push_back(v);
    step();
    cfg_valid = 1'b0;
    if (sb_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      r = sb_q.pop_front();
      if (r.legal) begin
        m_id = r.e_id; m_fb = r.e_fb; m_md = r.e_md; m_od = r.e_od; m_en = r.en;
        check("apply_err_range", err_range, 0);
        check("apply_err_timeout", err_timeout, 0);
        check("apply_lock_lost", lock_lost, 0);
        check("apply_busy", busy, 1);
        check("apply_enclk", pll_enclk, 0);
        check("apply_ready", cfg_ready, 0);
        check_sels("apply");
      end else begin
        check("range_err", err_range, 1);
        check("range_locked", locked, 1);
        check("range_ready", cfg_ready, 1);
        check("range_enclk", pll_enclk, m_en);
        check_sels("range");
      end
    end
  endtask

  task automatic lock_seq(input int delay);
    int n = 0;
    while (!pll_reset && n < 5) begin step(); n++; end
    check("rst_rise", pll_reset, 1);
    n = 0;
    while (pll_reset && n < 200) begin step(); n++; end
    check("rst_len", n, RC);
    repeat (delay) step();
    check("wait_unlocked", locked, 0);
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 300) begin step(); n++; end
    check("lock_latency", n, LS + 2);
    check("run_enclk", pll_enclk, m_en);
    check("run_busy", busy, 0);
    check_sels("run");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw_rst;
    tbl[0] = '{7'd2,  7'd5,  8'd10,  {8'd4, 8'd4},    2'b11, 1'b1, 6'd62, 6'd59, 7'd118, {7'd124, 7'd124}};
    tbl[1] = '{7'd2,  7'd5,  8'd1,   {8'd4, 8'd4},    2'b11, 1'b0, '0, '0, '0, '0};
    tbl[2] = '{7'd64, 7'd1,  8'd128, {8'd128, 8'd1},  2'b01, 1'b1, 6'd0,  6'd63, 7'd0,   {7'd0, 7'd127}};
    tbl[3] = '{7'd0,  7'd5,  8'd10,  {8'd4, 8'd4},    2'b11, 1'b0, '0, '0, '0, '0};
    tbl[4] = '{7'd2,  7'd65, 8'd10,  {8'd4, 8'd4},    2'b11, 1'b0, '0, '0, '0, '0};
    tbl[5] = '{7'd2,  7'd5,  8'd129, {8'd4, 8'd4},    2'b11, 1'b0, '0, '0, '0, '0};
    tbl[6] = '{7'd2,  7'd5,  8'd10,  {8'd0, 8'd4},    2'b11, 1'b0, '0, '0, '0, '0};
    tbl[7] = '{7'd1,  7'd64, 8'd2,   {8'd7, 8'd100},  2'b10, 1'b1, 6'd63, 6'd0,  7'd126, {7'd121, 7'd28}};

    rst = 1'b1; cfg_valid = 1'b0; pll_lock = 1'b0;
    cfg_idiv = '0; cfg_fbdiv = '0; cfg_mdiv = '0; cfg_odiv = '0; cfg_en = '0;
    set_defaults();
    repeat (3) step();
    check("rst_pll_reset", pll_reset, 0);
    check("rst_busy", busy, 1);
    check("rst_locked", locked, 0);
    check("rst_enclk", pll_enclk, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_flags", {err_range, err_timeout, lock_lost}, 0);
    check_sels("rst");

    rst = 1'b0;
    lock_seq(10);

    for (int i = 0; i < 8; i++) begin
      offer(tbl[i]);
      if (tbl[i].legal) lock_seq(10);
    end

    // Lock drop while running.
    pll_lock = 1'b0;
    n = 0;
    while (!lock_lost && n < 10) begin step(); n++; end
    check("lost_latency_ok", n <= 3, 1);
    check("lost_locked", locked, 0);
    check("lost_enclk", pll_enclk, 0);
`ifdef SYS_PLL_RELOCK_EN
    n = 0;
    while (!pll_reset && n < 20) begin step(); n++; end
    check("relock_rst_pulse", pll_reset, 1);
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 300) begin step(); n++; end
    check("relock_locked", locked, 1);
`else
    saw_rst = 1'b0;
    while (n < 5) begin step(); n++; saw_rst |= pll_reset; end
    check("lost_busy", busy, 0);
    pll_lock = 1'b1;
    n = 0;
    while (!locked && n < 300) begin step(); n++; saw_rst |= pll_reset; end
    check("relock_latency", n, LS + 2);
    check("relock_no_rst", saw_rst, 0);
    check("relock_enclk", pll_enclk, m_en);
`endif
    check("lost_sticky", lock_lost, 1);

    // Lock never arrives: timeout into FAULT, then recover from FAULT.
    offer(tbl[0]);
    n = 0;
    while (!pll_reset && n < 5) begin step(); n++; end
    n = 0;
    while (pll_reset && n < 200) begin step(); n++; end
    check("to_rst_len", n, RC);
    n = 0;
    while (!err_timeout && n < 300) begin step(); n++; end
    check("timeout_cycle", n, LT);
    check("fault_enclk", pll_enclk, 0);
    check("fault_ready", cfg_ready, 1);
    check("fault_busy", busy, 0);
    check("fault_locked", locked, 0);
    offer(tbl[2]);
    lock_seq(10);

    // Reset asserted in the middle of the PLL reset pulse.
    offer(tbl[7]);
    n = 0;
    while (!pll_reset && n < 5) begin step(); n++; end
    repeat (3) step();
    check("mid_in_rst", pll_reset, 1);
    rst = 1'b1;
    step();
    set_defaults();
    check("mid_pll_reset", pll_reset, 0);
    check("mid_busy", busy, 1);
    check("mid_locked", locked, 0);
    check_sels("mid");
    rst = 1'b0;
    lock_seq(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
